// File: rtl/usb_sniffer_mem_writer.sv
// Capture-buffer write engine: stores sniffer log words into a ring buffer in memory
// as single-word writes, tracking outstanding writes, wrap, full, overflow and bus errors.
module usb_sniffer_mem_writer #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cfg_enable_i,
    input  logic        cfg_cont_i,
    input  logic [31:0] cfg_base_i,
    input  logic [31:0] cfg_end_i,
    input  logic        data_valid_i,
    input  logic [31:0] data_i,
    output logic        data_accept_o,
    output logic [3:0]  outport_wr_o,
    output logic        outport_rd_o,
    output logic [7:0]  outport_len_o,
    output logic [31:0] outport_addr_o,
    output logic [31:0] outport_write_data_o,
    input  logic        outport_accept_i,
    input  logic        outport_ack_i,
    input  logic        outport_error_i,
    output logic [31:0] sts_wr_ptr_o,
    output logic        sts_wrapped_o,
    output logic        sts_full_o,
    output logic        sts_overflow_o,
    output logic        sts_error_o,
    output logic        sts_busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPED,
        ST_DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      wr_ptr_q, wr_ptr_d;
    logic             req_valid_q, req_valid_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic [31:0]      req_data_q, req_data_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             wrapped_q, wrapped_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic             error_q, error_d;

    logic [31:0]      base_aligned;
    logic [31:0]      end_aligned;
    logic [31:0]      nxt_ptr;
    logic [CNT_W:0]   in_flight;
    logic             credit_ok;
    logic             issue;
    logic             data_accept;

    assign base_aligned = cfg_base_i & ~32'h3;
    assign end_aligned  = cfg_end_i & ~32'h3;
    assign nxt_ptr      = wr_ptr_q + 32'd4;
    assign in_flight    = {1'b0, outstanding_q} + {{CNT_W{1'b0}}, req_valid_q};
    assign credit_ok    = in_flight < (CNT_W+1)'(MAX_OUTSTANDING);
    assign issue        = req_valid_q && outport_accept_i;

    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        req_data_d    = req_data_q;
        outstanding_d = outstanding_q;
        wrapped_d     = wrapped_q;
        full_d        = full_q;
        overflow_d    = overflow_q;
        error_d       = error_q;
        data_accept   = 1'b0;

        if (issue) begin
            req_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_enable_i) begin
                    state_d    = ST_RUN;
                    wr_ptr_d   = base_aligned;
                    wrapped_d  = 1'b0;
                    full_d     = 1'b0;
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                end
            end
            ST_RUN: begin
                data_accept = (!req_valid_q || outport_accept_i) && credit_ok;
                if (data_valid_i && data_accept) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = wr_ptr_q;
                    req_data_d  = data_i;
                    // Live base/end compare; the buffer end is exclusive.
                    if (nxt_ptr >= end_aligned) begin
                        if (cfg_cont_i) begin
                            wr_ptr_d  = base_aligned;
                            wrapped_d = 1'b1;
                        end else begin
                            wr_ptr_d = nxt_ptr;
                            full_d   = 1'b1;
                            state_d  = ST_STOPPED;
                        end
                    end else begin
                        wr_ptr_d = nxt_ptr;
                    end
                end
                if (!cfg_enable_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_STOPPED: begin
                // Buffer full: keep the sniffer flowing and account for what is lost.
                data_accept = 1'b1;
                if (data_valid_i) begin
                    overflow_d = 1'b1;
                end
                if (!cfg_enable_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!req_valid_q && outstanding_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue && !outport_ack_i) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!issue && outport_ack_i && outstanding_q != '0) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (outport_ack_i && outport_error_i) begin
            error_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            outstanding_q <= '0;
            wrapped_q     <= 1'b0;
            full_q        <= 1'b0;
            overflow_q    <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_data_q    <= req_data_d;
            outstanding_q <= outstanding_d;
            wrapped_q     <= wrapped_d;
            full_q        <= full_d;
            overflow_q    <= overflow_d;
            error_q       <= error_d;
        end
    end

    assign data_accept_o        = data_accept;
    assign outport_wr_o         = req_valid_q ? 4'hF : 4'h0;
    assign outport_rd_o         = 1'b0;
    assign outport_len_o        = 8'd0;
    assign outport_addr_o       = req_addr_q;
    assign outport_write_data_o = req_data_q;
    assign sts_wr_ptr_o         = wr_ptr_q;
    assign sts_wrapped_o        = wrapped_q;
    assign sts_full_o           = full_q;
    assign sts_overflow_o       = overflow_q;
    assign sts_error_o          = error_q;
    assign sts_busy_o           = (state_q != ST_IDLE);

endmodule
